mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for a shared memory port.
// Picks one requester, holds its grant, the mux select and the port enable
// for MEM_LATENCY cycles, pulses done in the last granted cycle, then spends
// one idle cycle before the next arbitration. All outputs are registered.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int MEM_LATENCY = 2,
  localparam int SEL_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 mem_en,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy
);

  // Counter only needs to hold MEM_LATENCY-1; keep at least one bit.
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_INIT = SEL_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [SEL_WIDTH-1:0] last_ptr_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic                 mem_en_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;

  logic [SEL_WIDTH-1:0] win_d;
  logic [NUM_REQ-1:0]   win_oh_d;

  // First set request bit at or after last+1, wrapping at NUM_REQ-1 -> 0.
  // Works for non-power-of-2 NUM_REQ since the wrap uses a true modulo.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]   r,
    input logic [SEL_WIDTH-1:0] last
  );
    logic [SEL_WIDTH-1:0] w;
    logic [SEL_WIDTH-1:0] idx_s;
    logic                 found;
    int                   idx;
    w     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx   = (int'(last) + i) % NUM_REQ;
      idx_s = SEL_WIDTH'(idx);
      if (!found && r[idx_s]) begin
        w     = idx_s;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [SEL_WIDTH-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin winner for the current request vector.
  always_comb begin
    win_d    = rr_pick(req, last_ptr_q);
    win_oh_d = to_onehot(win_d);
  end

  // Arbitration FSM with registered grant, select, enable and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_ptr_q <= LAST_INIT;
      gnt_q      <= '0;
      sel_q      <= '0;
      mem_en_q   <= 1'b0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            state_q    <= ST_ACCESS;
            cnt_q      <= CNT_LOAD;
            last_ptr_q <= win_d;
            gnt_q      <= win_oh_d;
            sel_q      <= win_d;
            mem_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            // With a single-cycle access the grant cycle is also the last one.
            done_q     <= (MEM_LATENCY == 1) ? win_oh_d : '0;
          end else begin
            // sel keeps its last value so the mux output stays stable.
            gnt_q    <= '0;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            mem_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= '0;
          end else begin
            cnt_q  <= cnt_q - CNT_W'(1);
            // Raise done for the cycle in which the count reaches zero.
            done_q <= (cnt_q == CNT_W'(1)) ? gnt_q : '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          gnt_q    <= '0;
          mem_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= '0;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign mem_en = mem_en_q;
  assign done   = done_q;
  assign busy   = busy_q;

  a_gnt_onehot0  : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_done_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(done));
  a_done_in_gnt  : assert property (@(posedge clk) disable iff (rst) (done & ~gnt) == '0);
  a_en_gnt       : assert property (@(posedge clk) disable iff (rst) mem_en == (gnt != '0));
  a_en_busy      : assert property (@(posedge clk) disable iff (rst) mem_en == busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (3 requesters / latency 2 and
// 2 requesters / latency 1) checked every cycle against a remaining-cycles
// model, plus literal expectations for the directed scenarios.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req_a;
  logic [1:0] req_b;

  logic [2:0] gnt_a, done_a;
  logic [1:0] sel_a;
  logic       mem_en_a, busy_a;
  logic [1:0] gnt_b, done_b;
  logic [0:0] sel_b;
  logic       mem_en_b, busy_b;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // Model state per instance: k=0 -> A, k=1 -> B.
  int nreq[2] = '{3, 2};
  int lat[2]  = '{2, 1};
  int left[2];   // granted cycles still to be shown, 0 = idle
  int cur[2];    // requester currently granted
  int last[2];   // last granted requester
  int selm[2];   // expected sel

  int exp_b6[6] = '{1, 0, 2, 0, 1, 0};

  mem_port_arbiter #(.NUM_REQ(3), .MEM_LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a),
    .mem_en(mem_en_a), .done(done_a), .busy(busy_a)
  );

  mem_port_arbiter #(.NUM_REQ(2), .MEM_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b),
    .mem_en(mem_en_b), .done(done_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Reference model: advances on each rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int r;
      r = (k == 0) ? int'(req_a) : int'(req_b);
      if (rst) begin
        left[k] = 0;
        last[k] = nreq[k] - 1;
        selm[k] = 0;
      end else if (left[k] > 0) begin
        left[k] = left[k] - 1;
      end else if (r != 0) begin
        for (int j = 1; j <= nreq[k]; j++) begin
          int w;
          w = (last[k] + j) % nreq[k];
          if (left[k] == 0 && ((r >> w) & 1) == 1) begin
            cur[k]  = w;
            last[k] = w;
            selm[k] = w;
            left[k] = lat[k];
          end
        end
      end
    end
    started = 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int eg, ed;
    if (!started) return;
    eg = (left[0] > 0) ? (1 << cur[0]) : 0;
    ed = (left[0] == 1) ? eg : 0;
    cmp("a_gnt",    int'(gnt_a),    eg);
    cmp("a_sel",    int'(sel_a),    selm[0]);
    cmp("a_mem_en", int'(mem_en_a), int'(left[0] > 0));
    cmp("a_busy",   int'(busy_a),   int'(left[0] > 0));
    cmp("a_done",   int'(done_a),   ed);
    eg = (left[1] > 0) ? (1 << cur[1]) : 0;
    ed = (left[1] == 1) ? eg : 0;
    cmp("b_gnt",    int'(gnt_b),    eg);
    cmp("b_sel",    int'(sel_b),    selm[1]);
    cmp("b_mem_en", int'(mem_en_b), int'(left[1] > 0));
    cmp("b_busy",   int'(busy_b),   int'(left[1] > 0));
    cmp("b_done",   int'(done_b),   ed);
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      left[k] = 0;
      cur[k]  = 0;
      last[k] = nreq[k] - 1;
      selm[k] = 0;
    end
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    cmp("rst_gnt",    int'(gnt_a),    0);
    cmp("rst_sel",    int'(sel_a),    0);
    cmp("rst_mem_en", int'(mem_en_a), 0);
    cmp("rst_busy",   int'(busy_a),   0);

    // Single requester, latency 2.
    rst   = 1'b0;
    req_a = 3'b001;
    tick();
    cmp("t1_gnt_c1",  int'(gnt_a),    1);
    cmp("t1_sel_c1",  int'(sel_a),    0);
    cmp("t1_en_c1",   int'(mem_en_a), 1);
    cmp("t1_done_c1", int'(done_a),   0);
    tick();
    cmp("t1_gnt_c2",  int'(gnt_a),    1);
    cmp("t1_done_c2", int'(done_a),   1);
    tick();
    cmp("t1_gnt_c3",  int'(gnt_a),    0);
    cmp("t1_busy_c3", int'(busy_a),   0);
    req_a = '0;
    tick();

    // All requesting on A; both requesting on B (latency 1).
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 3'b111;
    req_b = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 3 == 1) begin
        cmp("t2_gnt", int'(gnt_a), 1 << ((c / 3) % 3));
        cmp("t2_sel", int'(sel_a), (c / 3) % 3);
      end
      if (c <= 6) begin
        cmp("t6_gnt",  int'(gnt_b),  exp_b6[c-1]);
        cmp("t6_done", int'(done_b), exp_b6[c-1]);
      end
    end

    // Requesters 0 and 2 alternate; requester 1 idle.
    rst   = 1'b1;
    req_a = '0;
    tick();
    rst   = 1'b0;
    req_a = 3'b101;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 3 == 1)
        cmp("t3_gnt", int'(gnt_a), ((c / 3) % 2 == 0) ? 1 : 4);
      cmp("t3_no_r1", int'(gnt_a[1]), 0);
    end

    // Request dropped mid-access.
    rst   = 1'b1;
    req_a = '0;
    tick();
    rst   = 1'b0;
    req_a = 3'b010;
    tick();
    cmp("t4_gnt_c1", int'(gnt_a), 2);
    req_a = '0;
    tick();
    cmp("t4_gnt_c2",  int'(gnt_a),  2);
    cmp("t4_done_c2", int'(done_a), 2);
    tick();
    cmp("t4_gnt_c3", int'(gnt_a), 0);
    cmp("t4_sel_c3", int'(sel_a), 1);
    tick();
    cmp("t4_sel_c4",  int'(sel_a),  1);
    cmp("t4_busy_c4", int'(busy_a), 0);

    // Reset in the middle of an access.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req_a = 3'b011;
    tick();
    cmp("t5_gnt_c1", int'(gnt_a), 1);
    rst = 1'b1;
    tick();
    cmp("t5_gnt_c2",  int'(gnt_a),    0);
    cmp("t5_en_c2",   int'(mem_en_a), 0);
    cmp("t5_busy_c2", int'(busy_a),   0);
    cmp("t5_done_c2", int'(done_a),   0);
    rst = 1'b0;
    tick();
    cmp("t5_gnt_c3", int'(gnt_a), 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 800; n++) begin
      tick();
      req_a = 3'($urandom_range(0, 7));
      req_b = 2'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
